// File: rtl/uart_rx_framer.sv
// UART receive framer: start detection, bit sampling and a
// valid/ack holding register in front of the character consumer.
//
// Ports:
//   clk, reset          16x-baud clock, async active-high reset
//   serialIn            raw RX line (idles high)
//   SRclk               mid-bit sample pulse from the bit counter
//   charReceived        counter flag: last sample of the frame taken
//   dataAck             consumer accepts the held character
//   enable              run/clear control to the bit counter
//   data, dataValid     held character and its valid flag
//   framingError        held character had a 0 stop bit
//   overrun             a finished character was dropped
//   busy                framer is inside a frame
module uart_rx_framer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serialIn,
    input  logic       SRclk,
    input  logic       charReceived,
    input  logic       dataAck,
    output logic       enable,
    output logic [7:0] data,
    output logic       dataValid,
    output logic       framingError,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_END,
        LOAD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncIn;
    logic                   syncPrev;
    logic [7:0]             shift;
    logic [2:0]             bit_idx;
    logic                   stopBit;
    logic                   load;
    logic                   accept;

    assign syncIn = sync_q[SYNC_STAGES-1];

    // Flops preset to 1 so an idle line out of reset is not a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '1;
            syncPrev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], serialIn};
            syncPrev <= syncIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (syncPrev && !syncIn) begin
                    state_next = START;
                end
            end
            START: begin
                if (SRclk) begin
                    state_next = syncIn ? IDLE : DATA;
                end
            end
            DATA: begin
                if (SRclk && bit_idx == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (SRclk) begin
                    state_next = WAIT_END;
                end
            end
            WAIT_END: begin
                if (charReceived) begin
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter runs only while a frame is in progress; LOAD clears it.
    always_comb begin
        enable = 1'b0;
        busy   = 1'b0;
        case (state)
            START, DATA, STOP, WAIT_END: begin
                enable = 1'b1;
                busy   = 1'b1;
            end
            LOAD:    busy = 1'b1;
            default: ;
        endcase
    end

    assign load   = (state == WAIT_END) && charReceived;
    assign accept = !dataValid || dataAck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_idx <= '0;
            stopBit <= 1'b0;
        end else if (SRclk) begin
            case (state)
                START: bit_idx <= '0;
                DATA: begin
                    shift   <= {syncIn, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                STOP:    stopBit <= syncIn;
                default: ;
            endcase
        end
    end

    // A load on the ack edge replaces the held character directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data         <= '0;
            dataValid    <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else if (load && accept) begin
            data         <= shift;
            framingError <= ~stopBit;
            dataValid    <= 1'b1;
            overrun      <= 1'b0;
        end else if (load) begin
            overrun <= 1'b1;
        end else if (dataAck && dataValid) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receive-side framing controller for the UART path: it watches the raw serial line, detects start bits, and gates the bit/sample counter through `enable`. It samples the line on each mid-bit `SRclk` pulse, assembles the 8-bit character, and hands it to the consumer through a valid/ack holding register. It sits directly upstream of the character bit counter, which it drives, and consumes that counter's `SRclk` and `charReceived` outputs. `clk` is the 16x-baud sample clock shared with the counter.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the `serialIn` synchronizer (minimum 2).
- `clk`  input  1: 16x-baud sample clock, rising-edge.
- `reset`  input  1: asynchronous, active-high reset.
- `serialIn`  input  1: raw asynchronous RX line; idles high.
- `SRclk`  input  1: one-cycle mid-bit pulse from the bit counter, once per bit.
- `charReceived`  input  1: counter level flag; high after the last sample of bit 9 until `enable` drops.
- `dataAck`  input  1: consumer accepts the held character.
- `enable`  output  1: run/clear control to the bit counter; low clears the counter.
- `data`  output  8: received character, LSB first on the wire.
- `dataValid`  output  1: `data`/`framingError` hold an unaccepted character.
- `framingError`  output  1: the held character's stop bit sampled 0.
- `overrun`  output  1: a completed character was discarded because `dataValid` was still set.
- `busy`  output  1: FSM not in IDLE.

## Operation
- Async reset: every synchronizer flop is set to 1, so idle-line reset causes no false start.
- Async reset: FSM goes to IDLE; `enable`, `data`, `dataValid`, `framingError`, `overrun` and `busy` all go to 0; the shift register clears.
- `syncIn` is the last synchronizer stage; `syncPrev` is `syncIn` delayed one cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_END, LOAD. `enable` = 1 in START, DATA, STOP and WAIT_END; 0 in IDLE and LOAD.
- IDLE: `syncPrev`=1 and `syncIn`=0 (falling edge) -> START. A line held low never retriggers; it must go high first.
- START: on `SRclk`, sample `syncIn`.
  - Sample 1 (false start): -> IDLE; no output changes.
  - Sample 0: -> DATA with bit index 0.
- DATA: on each `SRclk`, shift `syncIn` into the shift register MSB, shifting right. After index 7 (8 pulses) -> STOP.
- STOP: on `SRclk`, latch `stopBit` = `syncIn` -> WAIT_END.
- WAIT_END: on `charReceived`=1 -> LOAD, and on the same edge update the holding register:
  - `dataValid`=0, or `dataAck`=1 on this edge: `data` <= shift register; `framingError` <= ~`stopBit`; `dataValid` <= 1.
  - Otherwise: discard the character; `overrun` <= 1; `data` and `framingError` unchanged.
- LOAD: one cycle with `enable` low so the counter clears -> IDLE.
- Handshake:
  - `dataAck`=1 with `dataValid`=1 clears `dataValid` and `overrun` on that edge.
  - `dataAck` with `dataValid`=0 is ignored.
  - Ack and load on the same edge: new character loaded, `dataValid` stays 1, no overrun.
- `SRclk` pulses outside START, DATA and STOP are ignored. `charReceived` is ignored outside WAIT_END.
- Reset mid-frame aborts immediately: `enable` drops asynchronously and the partial character is lost.

## Timing
- `serialIn` falling edge -> `enable` high after `SYNC_STAGES`+1 clk edges (3 at default).
- Samples are taken in the cycle `SRclk` is high. Frame = 10 bits x 16 clk = 160 clk of counter run time.
- `charReceived` first high -> `dataValid` high on the next edge (1-cycle latency). `enable` is low for exactly one cycle (LOAD).
- Back-to-back frames: a start edge arriving while in LOAD is caught in IDLE, provided `syncPrev`=1 and `syncIn`=0 there. Minimum stop-to-start gap is one bit time.
- `dataAck` -> `dataValid` low on the next edge.
- `busy` = 1 from the START entry edge through the LOAD exit edge.

## Test plan
- Reset: assert `reset` mid-idle -> all outputs 0 and `enable`=0 immediately (no clock needed). Release and hold `serialIn`=1 for 50 clk -> no `enable`.
- Nominal frame: send 0x55 with stop=1 at 16 clk/bit -> `data`=0x55, `dataValid`=1, `framingError`=0, `overrun`=0. Pulse `dataAck` -> `dataValid`=0 next cycle.
- Framing error: send 0xA3 with stop=0, then hold the line low -> `data`=0xA3, `framingError`=1. No new frame until the line returns high then falls.
- Glitch: `serialIn` low 4 clk, then high -> `enable` rises then drops after the first `SRclk`; `dataValid` stays 0.
- Overrun: send 0x12 then 0x34 with no ack -> `data`=0x12, `overrun`=1. Ack -> `dataValid`=0, `overrun`=0. A simultaneous ack+load case loads the new byte with `overrun`=0.
- Reset mid-frame: assert `reset` after 5 data bits -> `enable`=0, `busy`=0. Then send 0x0F -> `data`=0x0F, `framingError`=0.
